// File: rtl/press_request_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : press_request_fifo
//  Brief    : Queues debounced up/down press requests and replays them
//             toward the up/down counter in order. Each press is taken
//             in with a four-phase req/ack handshake and sent out with one.
//  Option   : PRESS_FIFO_OVERFLOW_DROP_EN -- when defined, a press that
//             arrives while the FIFO is full is acknowledged but dropped,
//             and the sticky overflow flag is set. When undefined, a full
//             FIFO holds off the request and overflow is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module press_request_fifo #(
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  upReq,
    input  logic                  downReq,
    output logic                  upAck,
    output logic                  downAck,
    output logic                  outUpReq,
    output logic                  outDownReq,
    input  logic                  outUpAck,
    input  logic                  outDownAck,
    output logic [DEPTH_BITS:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    localparam int                  c_DEPTH_N = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] c_DEPTH   = {1'b1, {DEPTH_BITS{1'b0}}};

    typedef enum logic [0:0] {
        IN_IDLE  = 1'b0,
        IN_ACKED = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE    = 2'd0,
        OUT_REQ     = 2'd1,
        OUT_WAITLOW = 2'd2
    } out_state_t;

    in_state_t               up_st_q, up_st_d;
    in_state_t               dn_st_q, dn_st_d;
    out_state_t              out_st_q, out_st_d;

    logic [c_DEPTH_N-1:0]    mem_q;
    logic [DEPTH_BITS-1:0]   wr_ptr_q;
    logic [DEPTH_BITS-1:0]   rd_ptr_q;
    logic [DEPTH_BITS:0]     count_q, count_d;
    logic                    dir_q, dir_d;

    logic                    full_w;
    logic                    empty_w;
    logic                    can_accept;
    logic                    up_pend;
    logic                    dn_pend;
    logic                    up_grant;
    logic                    dn_grant;
    logic                    push;
    logic                    pop;
    logic                    ack_match;

    assign full_w  = (count_q == c_DEPTH);
    assign empty_w = (count_q == '0);

    // Write arbitration: one push per cycle, up wins a tie with down.
    // Fullness is judged on the pre-edge count, so a same-edge pop never
    // opens space for a push.
    always_comb begin
        up_pend  = (up_st_q == IN_IDLE) && upReq;
        dn_pend  = (dn_st_q == IN_IDLE) && downReq;
`ifdef PRESS_FIFO_OVERFLOW_DROP_EN
        can_accept = 1'b1;
`else
        can_accept = !full_w;
`endif
        up_grant = up_pend && can_accept;
        dn_grant = dn_pend && !up_pend && can_accept;
        push     = (up_grant || dn_grant) && !full_w;
    end

    // Input handshake FSMs: ack rises with the granted push, drops once req is seen low.
    always_comb begin
        up_st_d = up_st_q;
        dn_st_d = dn_st_q;
        case (up_st_q)
            IN_IDLE:  if (up_grant) up_st_d = IN_ACKED;
            IN_ACKED: if (!upReq)   up_st_d = IN_IDLE;
            default:                up_st_d = IN_IDLE;
        endcase
        case (dn_st_q)
            IN_IDLE:  if (dn_grant) dn_st_d = IN_ACKED;
            IN_ACKED: if (!downReq) dn_st_d = IN_IDLE;
            default:                dn_st_d = IN_IDLE;
        endcase
    end

    // Output handshake FSM: latch the head direction, request, pop on ack, wait for ack low.
    always_comb begin
        out_st_d  = out_st_q;
        dir_d     = dir_q;
        pop       = 1'b0;
        ack_match = dir_q ? outUpAck : outDownAck;
        case (out_st_q)
            OUT_IDLE: begin
                if (!empty_w) begin
                    dir_d    = mem_q[rd_ptr_q];
                    out_st_d = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ack_match) begin
                    pop      = 1'b1;
                    out_st_d = OUT_WAITLOW;
                end
            end
            OUT_WAITLOW: begin
                if (!ack_match) out_st_d = OUT_IDLE;
            end
            default: out_st_d = OUT_IDLE;
        endcase
    end

    // Occupancy is tracked separately from the pointers so full is unambiguous.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State, storage and pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            up_st_q  <= IN_IDLE;
            dn_st_q  <= IN_IDLE;
            out_st_q <= OUT_IDLE;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
        end else begin
            up_st_q  <= up_st_d;
            dn_st_q  <= dn_st_d;
            out_st_q <= out_st_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            if (push) begin
                mem_q[wr_ptr_q] <= up_grant;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef PRESS_FIFO_OVERFLOW_DROP_EN
    logic overflow_q;

    // Sticky flag: set whenever a press is acknowledged but could not be stored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if ((up_grant || dn_grant) && full_w) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign upAck      = (up_st_q == IN_ACKED);
    assign downAck    = (dn_st_q == IN_ACKED);
    assign outUpReq   = (out_st_q == OUT_REQ) && dir_q;
    assign outDownReq = (out_st_q == OUT_REQ) && !dir_q;
    assign count      = count_q;
    assign full       = full_w;
    assign empty      = empty_w;

endmodule
`default_nettype wire

// File: tb/tb_press_request_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_press_request_fifo
//  Brief    : Directed self-checking bench for press_request_fifo
//             (DEPTH_BITS = 2). Honours PRESS_FIFO_OVERFLOW_DROP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_press_request_fifo;

    localparam int DEPTH_BITS = 2;

    logic                clock      = 1'b0;
    logic                reset      = 1'b0;
    logic                upReq      = 1'b0;
    logic                downReq    = 1'b0;
    logic                outUpAck   = 1'b0;
    logic                outDownAck = 1'b0;
    logic                upAck;
    logic                downAck;
    logic                outUpReq;
    logic                outDownReq;
    logic [DEPTH_BITS:0] count;
    logic                full;
    logic                empty;
    logic                overflow;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    press_request_fifo #(.DEPTH_BITS(DEPTH_BITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .upReq      (upReq),
        .downReq    (downReq),
        .upAck      (upAck),
        .downAck    (downAck),
        .outUpReq   (outUpReq),
        .outDownReq (outDownReq),
        .outUpAck   (outUpAck),
        .outDownAck (outDownAck),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full four-phase input handshake for one press; ok=0 on timeout.
    task automatic press(input logic dir, output logic ok);
        ok = 1'b0;
        if (dir) upReq = 1'b1; else downReq = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dir ? upAck : downAck) begin
                ok = 1'b1;
                break;
            end
        end
        if (dir) upReq = 1'b0; else downReq = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (!(dir ? upAck : downAck)) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    // Plays the counter for one output handshake; reports direction seen.
    task automatic serve(output logic ok, output logic got_dir);
        ok      = 1'b0;
        got_dir = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outUpReq || outDownReq) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            got_dir = outUpReq;
            if (got_dir) outUpAck = 1'b1; else outDownAck = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (!(outUpReq || outDownReq)) begin
                    ok = 1'b1;
                    break;
                end
            end
            outUpAck   = 1'b0;
            outDownAck = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({upAck, downAck, outUpReq, outDownReq, full, empty, overflow} !== 7'b0000010) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000010", {upAck, downAck, outUpReq, outDownReq, full, empty, overflow});
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_press();
        upReq = 1'b1;
        tick();
        checks++;
        if ({upAck, outUpReq, count} !== {1'b1, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL single_ack: got upAck=%b outUpReq=%b count=%0d expected 1 0 1", upAck, outUpReq, count);
        end
        tick();
        checks++;
        if ({outUpReq, outDownReq} !== 2'b10) begin
            errors++;
            $display("FAIL single_outreq: got up=%b down=%b expected 1 0", outUpReq, outDownReq);
        end
        upReq    = 1'b0;
        outUpAck = 1'b1;
        tick();
        checks++;
        if ({outUpReq, upAck, empty, count} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL single_pop: got outUpReq=%b upAck=%b empty=%b count=%0d expected 0 0 1 0", outUpReq, upAck, empty, count);
        end
        outUpAck = 1'b0;
        repeat (3) tick();
        checks++;
        if ({outUpReq, outDownReq} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: got up=%b down=%b expected 0 0", outUpReq, outDownReq);
        end
    endtask

    task automatic test_queue();
        logic       ok;
        logic       all_ok;
        logic       got;
        logic [3:0] seq = 4'b1010;
        all_ok = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            press(seq[i], ok);
            all_ok = all_ok & ok;
        end
        checks++;
        if (all_ok !== 1'b1) begin
            errors++;
            $display("FAIL queue_push_handshake: got ok=%b expected 1", all_ok);
        end
        checks++;
        if ({count, full, empty} !== {3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL queue_full: got count=%0d full=%b empty=%b expected 4 1 0", count, full, empty);
        end
        for (int i = 3; i >= 0; i--) begin
            serve(ok, got);
            checks++;
            if ({ok, got} !== {1'b1, seq[i]}) begin
                errors++;
                $display("FAIL queue_replay%0d: got ok=%b dir=%b expected 1 %b", 3 - i, ok, got, seq[i]);
            end
        end
        checks++;
        if ({count, empty} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL queue_drained: got count=%0d empty=%b expected 0 1", count, empty);
        end
    endtask

    task automatic test_full_stall();
        logic ok;
        logic all_ok;
        logic got;
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            press(1'b0, ok);
            all_ok = all_ok & ok;
        end
        checks++;
        if ({all_ok, count, outDownReq} !== {1'b1, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL stall_fill: got ok=%b count=%0d outDownReq=%b expected 1 4 1", all_ok, count, outDownReq);
        end
        upReq = 1'b1;
`ifdef PRESS_FIFO_OVERFLOW_DROP_EN
        tick();
        checks++;
        if ({upAck, count, overflow} !== {1'b1, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL drop_ack: got upAck=%b count=%0d overflow=%b expected 1 4 1", upAck, count, overflow);
        end
        upReq = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            serve(ok, got);
            checks++;
            if ({ok, got} !== 2'b10) begin
                errors++;
                $display("FAIL drop_replay%0d: got ok=%b dir=%b expected 1 0", i, ok, got);
            end
        end
        repeat (4) tick();
        checks++;
        if ({outUpReq, outDownReq, count, overflow} !== {2'b00, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL drop_never_emitted: got up=%b down=%b count=%0d overflow=%b expected 0 0 0 1", outUpReq, outDownReq, count, overflow);
        end
`else
        repeat (3) tick();
        checks++;
        if ({upAck, count, overflow} !== {1'b0, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold: got upAck=%b count=%0d overflow=%b expected 0 4 0", upAck, count, overflow);
        end
        outDownAck = 1'b1;
        tick();
        checks++;
        if ({upAck, count, outDownReq} !== {1'b0, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL stall_pop_edge: got upAck=%b count=%0d outDownReq=%b expected 0 3 0", upAck, count, outDownReq);
        end
        tick();
        checks++;
        if ({upAck, count, full} !== {1'b1, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL stall_release: got upAck=%b count=%0d full=%b expected 1 4 1", upAck, count, full);
        end
        upReq      = 1'b0;
        outDownAck = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            serve(ok, got);
            checks++;
            if ({ok, got} !== {1'b1, (i == 3)}) begin
                errors++;
                $display("FAIL stall_replay%0d: got ok=%b dir=%b expected 1 %b", i, ok, got, (i == 3));
            end
        end
`endif
    endtask

    task automatic test_simultaneous();
        logic ok;
        logic got;
        upReq   = 1'b1;
        downReq = 1'b1;
        tick();
        checks++;
        if ({upAck, downAck, count} !== {1'b1, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL simul_first: got upAck=%b downAck=%b count=%0d expected 1 0 1", upAck, downAck, count);
        end
        tick();
        checks++;
        if ({downAck, count, outUpReq} !== {1'b1, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL simul_second: got downAck=%b count=%0d outUpReq=%b expected 1 2 1", downAck, count, outUpReq);
        end
        upReq   = 1'b0;
        downReq = 1'b0;
        tick();
        serve(ok, got);
        checks++;
        if ({ok, got} !== 2'b11) begin
            errors++;
            $display("FAIL simul_replay_up: got ok=%b dir=%b expected 1 1", ok, got);
        end
        serve(ok, got);
        checks++;
        if ({ok, got} !== 2'b10) begin
            errors++;
            $display("FAIL simul_replay_down: got ok=%b dir=%b expected 1 0", ok, got);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic all_ok;
        logic [2:0] seq = 3'b011;
        all_ok = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            press(seq[i], ok);
            all_ok = all_ok & ok;
        end
        checks++;
        if ({all_ok, count, outDownReq} !== {1'b1, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_setup: got ok=%b count=%0d outDownReq=%b expected 1 3 1", all_ok, count, outDownReq);
        end
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({upAck, downAck, outUpReq, outDownReq, full, empty, count} !== {6'b000001, 3'd0}) begin
            errors++;
            $display("FAIL rstmid_async: got %b count=%0d expected 000001 0", {upAck, downAck, outUpReq, outDownReq, full, empty}, count);
        end
        tick();
        reset = 1'b1;
        repeat (5) tick();
        checks++;
        if ({outUpReq, outDownReq, count, empty} !== {2'b00, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_quiet: got up=%b down=%b count=%0d empty=%b expected 0 0 0 1", outUpReq, outDownReq, count, empty);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_queue();
        test_full_stall();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
